adder_arbiter: RTL and testbench

Round-robin arbiter that shares one registered `adder` instance between M requesters. It accepts one operand pair at a time through a valid/ready handshake and drives the pair into the adder. It then returns the N+1-bit sum, tagged with the requester index, on a valid/ready output port. It sits between several datapath producers and the single adder resource.

---
 rtl/adder_arbiter_pkg.sv | 15 +
 rtl/adder.sv | 17 +
 rtl/adder_arbiter.sv | 91 +++++++++
 tb/tb_adder_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: FSM encoding and
// requester-index width helper.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_idw(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/adder.sv
// Registered N-bit adder with a full-width (N+1) carry-out sum.
module adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   sum
);

  always_ff @(posedge clk) begin
    if (rst) sum <= '0;
    else     sum <= {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between M requesters,
// with a valid/ready result port tagged by requester index.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N   = 8,
  parameter int M   = 4,
  parameter int IDW = calc_idw(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req_valid,
  input  logic [M*N-1:0] req_a,
  input  logic [M*N-1:0] req_b,
  output logic [M-1:0]   req_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N:0]     out_sum,
  output logic [IDW-1:0] out_id
);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic [N-1:0]   op_a, op_b;
  logic [N:0]     sum;
  logic           any_valid, grant_en, accept;

  // First valid index at or after p, wrapping modulo M (M need not be 2^k).
  function automatic logic [IDW-1:0] rr_pick(input logic [M-1:0] v,
                                             input logic [IDW-1:0] p);
    int idx;
    rr_pick = '0;
    for (int k = M - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= M) idx = idx - M;
      if (v[idx]) rr_pick = IDW'(idx);
    end
  endfunction

  always_comb begin
    any_valid = |req_valid;
    grant_en  = !rst && (state == IDLE || (state == DONE && out_ready));
    accept    = grant_en && any_valid;
    grant_id  = rr_pick(req_valid, ptr);
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      // Operands only move on an accept, so the adder output holds through DONE.
      if (accept) begin
        op_a   <= req_a[int'(grant_id)*N +: N];
        op_b   <= req_b[int'(grant_id)*N +: N];
        out_id <= grant_id;
        ptr    <= (grant_id == IDW'(M - 1)) ? '0 : grant_id + 1'b1;
      end
      case (state)
        IDLE: if (any_valid) state <= CALC;
        CALC: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= any_valid ? CALC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  adder #(.N(N)) u_adder (
    .clk (clk),
    .rst (rst),
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  assign out_sum = out_valid ? sum : '0;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboarded bench for adder_arbiter: M=4 main instance plus an M=3 instance
// for the non-power-of-two pointer wrap.
module tb_adder_arbiter;
  localparam int N = 8, M = 4, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, out_valid, out_ready;
  logic [M-1:0]     req_valid, req_ready;
  logic [M*N-1:0]   req_a, req_b;
  logic [N:0]       out_sum;
  logic [IDW-1:0]   out_id;

  logic             rst3, ov3, or3;
  logic [2:0]       v3, rdy3;
  logic [3*N-1:0]   a3, b3;
  logic [N:0]       sum3;
  logic [1:0]       id3;

  int checks = 0, failures = 0;
  logic [N+IDW:0] sb_q[$];
  logic [N+IDW:0] sb_exp;

  adder_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id));

  adder_arbiter #(.N(N), .M(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_ready(rdy3), .out_valid(ov3), .out_ready(or3),
    .out_sum(sum3), .out_id(id3));

  // Scoreboard: expected {id,sum} pushed at grant, popped at output handshake.
  always @(negedge clk) begin
    if (rst) sb_q.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got id=%0d sum=%0d with empty queue", out_id, out_sum);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_id, out_sum} !== sb_exp) begin
            failures++;
            $display("FAIL sb_result got id=%0d sum=%0d exp id=%0d sum=%0d",
                     out_id, out_sum, sb_exp[N+IDW:N+1], sb_exp[N:0]);
          end
        end
      end
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          failures++;
          $display("FAIL grant_legal got ready=%b valid=%b exp one-hot subset", req_ready, req_valid);
        end
      end
      for (int i = 0; i < M; i++)
        if (req_ready[i])
          sb_q.push_back({IDW'(i), {1'b0, req_a[i*N +: N]} + {1'b0, req_b[i*N +: N]}});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    tick(); tick(); #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_id !== '0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b sum=%0d id=%0d rdy=%b exp 0 0 0 0000",
               out_valid, out_sum, out_id, req_ready);
    end
    req_valid = '0; rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_op(1, 8'd200, 8'd100); req_valid = 4'b0010; #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
    tick(); req_valid = '0; #1;
    checks++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_calc got rdy=%b v=%b exp 0000 0", req_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 9'd300 || out_id !== 2'd1) begin
      failures++; $display("FAIL single_result got v=%b sum=%0d id=%0d exp 1 300 1", out_valid, out_sum, out_id);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_idle got v=%b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [M-1:0] e1;
    int exp;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < M; i++) set_op(i, 8'(10 + i*40), 8'(3 + i*17));
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      exp = k % M;
      e1 = M'(1 << exp);
      #1;
      checks++;
      if (req_ready !== e1) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, e1); end
      tick();
      set_op(exp, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      #1;
      checks++;
      if (req_ready !== '0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL rr_calc k=%0d got rdy=%b v=%b exp 0000 0", k, req_ready, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== IDW'(exp)) begin
        failures++; $display("FAIL rr_result k=%0d got v=%b id=%0d exp 1 %0d", k, out_valid, out_id, exp);
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back_backpressure();
    set_op(2, 8'd17, 8'd9); set_op(3, 8'd40, 8'd2); req_valid = 4'b1100; #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    tick(); req_valid = 4'b1000; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 9'd26 || out_id !== 2'd2 || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold c=%0d got v=%b sum=%0d id=%0d rdy=%b exp 1 26 2 0000",
                 c, out_valid, out_sum, out_id, req_ready);
      end
      tick();
    end
    out_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_grant got=%b exp=1000", req_ready); end
    tick(); req_valid = '0; #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_consumed got v=%b exp 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 9'd42 || out_id !== 2'd3) begin
      failures++; $display("FAIL bp_next got v=%b sum=%0d id=%0d exp 1 42 3", out_valid, out_sum, out_id);
    end
    tick();
  endtask

  task automatic test_width();
    set_op(0, 8'd255, 8'd255); req_valid = 4'b0001; #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL width_grant got=%b exp=0001", req_ready); end
    tick(); req_valid = '0; tick();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 9'd510) begin
      failures++; $display("FAIL width_max got v=%b sum=%0d exp 1 510", out_valid, out_sum);
    end
    tick();
    set_op(0, 8'd0, 8'd0); req_valid = 4'b0001; #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL width_grant0 got=%b exp=0001", req_ready); end
    tick(); req_valid = '0; tick();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 9'd0 || out_id !== 2'd0) begin
      failures++; $display("FAIL width_zero got v=%b sum=%0d id=%0d exp 1 0 0", out_valid, out_sum, out_id);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < M; i++) set_op(i, 8'(i + 1), 8'(i + 5));
    req_valid = '1; #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rstmid_grant got=%b exp=0010", req_ready); end
    tick(); rst = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_id !== '0 || req_ready !== '0) begin
      failures++;
      $display("FAIL rstmid_state got v=%b sum=%0d id=%0d rdy=%b exp 0 0 0 0000",
               out_valid, out_sum, out_id, req_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_first got=%b exp=0001", req_ready); end
    tick(); req_valid = '0; tick();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_sum !== 9'd6) begin
      failures++; $display("FAIL rstmid_result got v=%b id=%0d sum=%0d exp 1 0 6", out_valid, out_id, out_sum);
    end
    tick();
  endtask

  task automatic test_m3_wrap();
    logic [2:0] e1;
    int exp;
    a3 = {8'd100, 8'd50, 8'd10};
    b3 = {8'd200, 8'd60, 8'd20};
    v3 = 3'b101; or3 = 1'b1;
    tick(); rst3 = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 2 : 0;
      e1 = 3'(1 << exp);
      checks++;
      if (rdy3 !== e1) begin failures++; $display("FAIL m3_grant k=%0d got=%b exp=%b", k, rdy3, e1); end
      tick(); tick();
      checks++;
      if (ov3 !== 1'b1 || id3 !== 2'(exp) || sum3 !== ((exp == 0) ? 9'd30 : 9'd300)) begin
        failures++;
        $display("FAIL m3_result k=%0d got v=%b id=%0d sum=%0d exp 1 %0d %0d",
                 k, ov3, id3, sum3, exp, (exp == 0) ? 30 : 300);
      end
    end
    v3 = '0;
    tick();
    checks++;
    if (ov3 !== 1'b0) begin failures++; $display("FAIL m3_drain got v=%b exp 0", ov3); end
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b1;
    v3 = '0; a3 = '0; b3 = '0; or3 = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_backpressure();
    test_width();
    test_reset_mid();
    test_m3_wrap();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d entries exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
